// File: rtl/csi_pkg.sv
// Shared definitions for the CSI-2 packet sequencer.
// Holds the data-type constants, packet header layout and field positions,
// the sequencer state encoding and a short/long packet classifier.
package csi_pkg;

    // Packet data types
    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    // Header field slice positions within the 32-bit header
    localparam int unsigned HDR_DT_LSB  = 0;
    localparam int unsigned HDR_DT_MSB  = 5;
    localparam int unsigned HDR_VC_LSB  = 6;
    localparam int unsigned HDR_VC_MSB  = 7;
    localparam int unsigned HDR_WC_LSB  = 8;
    localparam int unsigned HDR_WC_MSB  = 23;
    localparam int unsigned HDR_ECC_LSB = 24;
    localparam int unsigned HDR_ECC_MSB = 31;

    localparam int unsigned WC_W  = 16;
    // Remaining-byte counter also covers the two CRC bytes after the payload
    localparam int unsigned REM_W = WC_W + 1;

    typedef struct packed {
        logic [7:0]      ecc;
        logic [WC_W-1:0] wc;
        logic [1:0]      vc;
        logic [5:0]      dt;
    } csi_hdr_t;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StPayload = 1'b1
    } seq_state_e;

    function automatic logic is_long_pkt(input logic [5:0] dt);
        return dt >= DT_LONG_MIN;
    endfunction

endpackage

// File: rtl/csi_byte_counter.sv
// Byte accounting for one long packet.
// Tracks bytes left in the packet including CRC (remaining) and payload bytes
// left inside the word count (wc_left). Produces byte enables for the current
// word and flags the word that ends the packet.
// Ports:
//   sys_clk_i, reset_i : clock, asynchronous active-high reset
//   load_i, wc_i       : start a new packet with word count wc_i
//   consume_i          : one 4-byte payload word accepted this cycle
//   has_pix_o          : current word still carries payload bytes
//   be_o               : byte enables of the current word within WC
//   last_o             : current word is the last of the packet
module csi_byte_counter
    import csi_pkg::*;
(
    input  logic            sys_clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [WC_W-1:0] wc_i,
    input  logic            consume_i,
    output logic            has_pix_o,
    output logic [3:0]      be_o,
    output logic            last_o
);

    logic [REM_W-1:0] remaining_q, remaining_d;
    logic [WC_W-1:0]  wc_left_q, wc_left_d;

    always_comb begin
        remaining_d = remaining_q;
        wc_left_d   = wc_left_q;
        if (load_i) begin
            remaining_d = {1'b0, wc_i} + REM_W'(2);
            wc_left_d   = wc_i;
        end else if (consume_i) begin
            remaining_d = (remaining_q > REM_W'(4)) ? remaining_q - REM_W'(4) : '0;
            // Saturating subtract equals wc_left - min(4, wc_left)
            wc_left_d   = (wc_left_q > WC_W'(4)) ? wc_left_q - WC_W'(4) : '0;
        end
    end

    always_comb begin
        be_o = 4'h0;
        if (wc_left_q >= WC_W'(4)) begin
            be_o = 4'hF;
        end else begin
            unique case (wc_left_q[1:0])
                2'd3:    be_o = 4'h7;
                2'd2:    be_o = 4'h3;
                2'd1:    be_o = 4'h1;
                default: be_o = 4'h0;
            endcase
        end
    end

    assign has_pix_o = (wc_left_q != '0);
    assign last_o    = (remaining_q <= REM_W'(4));

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            remaining_q <= '0;
            wc_left_q   <= '0;
        end else begin
            remaining_q <= remaining_d;
            wc_left_q   <= wc_left_d;
        end
    end

endmodule

// File: rtl/csi_packet_sequencer.sv
// Packet-level controller for the 2-lane CSI-2 receive path (byte-word clock).
// Consumes validated headers and 32-bit payload words, tracks frame/line state,
// forwards pixel words with byte enables, skips unwanted long packets and CRC,
// holds rec_data high for exactly one packet and flags sticky errors.
// Ports:
//   sys_clk_i, reset_i          : clock, asynchronous active-high reset
//   hs_active_i                 : SoT FSM has HS receive enabled
//   hdr_valid_i, hdr_i, ecc_ok_i: header strobe, header, ECC match
//   word_valid_i, word_i        : payload word strobe and data
//   err_clr_i                   : clear sticky errors
//   rec_data_o                  : packet in progress
//   pix_valid_o/pix_data_o/pix_be_o : pixel word output
//   frame_start_o/frame_end_o/line_start_o : event pulses
//   in_frame_o, line_count_o, frame_count_o : frame/line state
//   err_ecc_o/err_timeout_o/err_trunc_o     : sticky error flags
// All outputs are registered.
module csi_packet_sequencer
    import csi_pkg::*;
#(
    parameter logic [5:0]  DT_PIXEL    = 6'h2A,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned LINE_W      = 12,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic               sys_clk_i,
    input  logic               reset_i,
    input  logic               hs_active_i,
    input  logic               hdr_valid_i,
    input  logic [31:0]        hdr_i,
    input  logic               ecc_ok_i,
    input  logic               word_valid_i,
    input  logic [31:0]        word_i,
    input  logic               err_clr_i,
    output logic               rec_data_o,
    output logic               pix_valid_o,
    output logic [31:0]        pix_data_o,
    output logic [3:0]         pix_be_o,
    output logic               frame_start_o,
    output logic               frame_end_o,
    output logic               line_start_o,
    output logic               in_frame_o,
    output logic [LINE_W-1:0]  line_count_o,
    output logic [FRAME_W-1:0] frame_count_o,
    output logic               err_ecc_o,
    output logic               err_timeout_o,
    output logic               err_trunc_o
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYC) + 1;

    csi_hdr_t hdr;
    assign hdr = csi_hdr_t'(hdr_i);

    logic unused_hdr;
    assign unused_hdr = ^{hdr.ecc, hdr.vc};

    seq_state_e state_q, state_d;
    logic       fwd_q, fwd_d;
    logic       first_q, first_d;
    logic [IdleW-1:0] idle_q, idle_d;

    logic               rec_data_q, rec_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic [31:0]        pix_data_q, pix_data_d;
    logic [3:0]         pix_be_q, pix_be_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_end_q, frame_end_d;
    logic               line_start_q, line_start_d;
    logic               in_frame_q, in_frame_d;
    logic [LINE_W-1:0]  line_count_q, line_count_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic               err_ecc_q, err_ecc_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_trunc_q, err_trunc_d;

    logic       set_ecc, set_timeout, set_trunc;
    logic       cnt_load, cnt_consume;
    logic       cnt_has_pix, cnt_last;
    logic [3:0] cnt_be;

    csi_byte_counter u_byte_counter (
        .sys_clk_i (sys_clk_i),
        .reset_i   (reset_i),
        .load_i    (cnt_load),
        .wc_i      (hdr.wc),
        .consume_i (cnt_consume),
        .has_pix_o (cnt_has_pix),
        .be_o      (cnt_be),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        fwd_d         = fwd_q;
        first_d       = first_q;
        idle_d        = idle_q;
        rec_data_d    = rec_data_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_be_d      = pix_be_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        line_start_d  = 1'b0;
        in_frame_d    = in_frame_q;
        line_count_d  = line_count_q;
        frame_count_d = frame_count_q;
        set_ecc       = 1'b0;
        set_timeout   = 1'b0;
        set_trunc     = 1'b0;
        cnt_load      = 1'b0;
        cnt_consume   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hdr_valid_i) begin
                    if (!ecc_ok_i) begin
                        set_ecc = 1'b1;
                    end else if (!is_long_pkt(hdr.dt)) begin
                        unique case (hdr.dt)
                            DT_FS: begin
                                frame_start_d = 1'b1;
                                in_frame_d    = 1'b1;
                                line_count_d  = '0;
                            end
                            DT_FE: begin
                                frame_end_d   = 1'b1;
                                in_frame_d    = 1'b0;
                                frame_count_d = frame_count_q + FRAME_W'(1);
                            end
                            DT_LS, DT_LE: ;
                            default: ;
                        endcase
                    end else begin
                        cnt_load   = 1'b1;
                        fwd_d      = (hdr.dt == DT_PIXEL) && in_frame_q;
                        first_d    = 1'b1;
                        idle_d     = '0;
                        rec_data_d = 1'b1;
                        state_d    = StPayload;
                    end
                end
            end

            StPayload: begin
                // Truncation beats a same-cycle word, which is dropped
                if (!hs_active_i) begin
                    set_trunc  = 1'b1;
                    rec_data_d = 1'b0;
                    state_d    = StIdle;
                end else if (word_valid_i) begin
                    cnt_consume = 1'b1;
                    idle_d      = '0;
                    if (fwd_q && cnt_has_pix) begin
                        pix_valid_d  = 1'b1;
                        pix_data_d   = word_i;
                        pix_be_d     = cnt_be;
                        line_start_d = first_q;
                        first_d      = 1'b0;
                    end
                    if (cnt_last) begin
                        rec_data_d = 1'b0;
                        state_d    = StIdle;
                        if (fwd_q) begin
                            line_count_d = line_count_q + LINE_W'(1);
                        end
                    end
                end else if (idle_q == IdleW'(TIMEOUT_CYC - 1)) begin
                    set_timeout = 1'b1;
                    rec_data_d  = 1'b0;
                    state_d     = StIdle;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
            end

            default: state_d = StIdle;
        endcase

        // A same-cycle error event wins over the clear
        err_ecc_d     = set_ecc     | (err_ecc_q     & ~err_clr_i);
        err_timeout_d = set_timeout | (err_timeout_q & ~err_clr_i);
        err_trunc_d   = set_trunc   | (err_trunc_q   & ~err_clr_i);
    end

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            fwd_q         <= 1'b0;
            first_q       <= 1'b0;
            idle_q        <= '0;
            rec_data_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_be_q      <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_start_q  <= 1'b0;
            in_frame_q    <= 1'b0;
            line_count_q  <= '0;
            frame_count_q <= '0;
            err_ecc_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_trunc_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fwd_q         <= fwd_d;
            first_q       <= first_d;
            idle_q        <= idle_d;
            rec_data_q    <= rec_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_be_q      <= pix_be_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_start_q  <= line_start_d;
            in_frame_q    <= in_frame_d;
            line_count_q  <= line_count_d;
            frame_count_q <= frame_count_d;
            err_ecc_q     <= err_ecc_d;
            err_timeout_q <= err_timeout_d;
            err_trunc_q   <= err_trunc_d;
        end
    end

    assign rec_data_o    = rec_data_q;
    assign pix_valid_o   = pix_valid_q;
    assign pix_data_o    = pix_data_q;
    assign pix_be_o      = pix_be_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign line_start_o  = line_start_q;
    assign in_frame_o    = in_frame_q;
    assign line_count_o  = line_count_q;
    assign frame_count_o = frame_count_q;
    assign err_ecc_o     = err_ecc_q;
    assign err_timeout_o = err_timeout_q;
    assign err_trunc_o   = err_trunc_q;

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// Scoreboard bench for csi_packet_sequencer: expected pixel words are queued
// as words are sent; a negedge monitor pops and compares on every pix_valid.
module tb_csi_packet_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hs_active = 1'b1;
    logic        hdr_valid = 1'b0;
    logic [31:0] hdr = '0;
    logic        ecc_ok = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word = '0;
    logic        err_clr = 1'b0;

    logic        rec_data, pix_valid, frame_start, frame_end, line_start, in_frame;
    logic [31:0] pix_data;
    logic [3:0]  pix_be;
    logic [11:0] line_count;
    logic [15:0] frame_count;
    logic        err_ecc, err_timeout, err_trunc;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        ls;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    csi_packet_sequencer dut (
        .sys_clk_i     (clk),
        .reset_i       (reset),
        .hs_active_i   (hs_active),
        .hdr_valid_i   (hdr_valid),
        .hdr_i         (hdr),
        .ecc_ok_i      (ecc_ok),
        .word_valid_i  (word_valid),
        .word_i        (word),
        .err_clr_i     (err_clr),
        .rec_data_o    (rec_data),
        .pix_valid_o   (pix_valid),
        .pix_data_o    (pix_data),
        .pix_be_o      (pix_be),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end),
        .line_start_o  (line_start),
        .in_frame_o    (in_frame),
        .line_count_o  (line_count),
        .frame_count_o (frame_count),
        .err_ecc_o     (err_ecc),
        .err_timeout_o (err_timeout),
        .err_trunc_o   (err_trunc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pixel word must match the head of the scoreboard
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pix: got data %0h be %0h, expected none",
                         pix_data, pix_be);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pix_data", pix_data, e.data);
                check("pix_be", {28'd0, pix_be}, {28'd0, e.be});
                check("line_start", {31'd0, line_start}, {31'd0, e.ls});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [5:0] dt, input logic [15:0] wc, input logic ok);
        hdr_valid = 1'b1;
        hdr       = {8'h5C, wc, 2'b00, dt};
        ecc_ok    = ok;
        tick();
        hdr_valid = 1'b0;
        ecc_ok    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        word_valid = 1'b1;
        word       = w;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic expect_pix(input logic [31:0] d, input logic [3:0] be, input logic ls);
        exp_t e;
        e.data = d;
        e.be   = be;
        e.ls   = ls;
        exp_q.push_back(e);
    endtask

    initial begin
        int n;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_rec_data", {31'd0, rec_data}, 32'd0);
        check("rst_in_frame", {31'd0, in_frame}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_errs", {29'd0, err_ecc, err_timeout, err_trunc}, 32'd0);

        // FS / FE
        send_hdr(6'h00, 16'd0, 1'b1);
        check("fs_pulse", {31'd0, frame_start}, 32'd1);
        check("fs_in_frame", {31'd0, in_frame}, 32'd1);
        check("fs_line_count", {20'd0, line_count}, 32'd0);
        tick();
        check("fs_pulse_end", {31'd0, frame_start}, 32'd0);
        send_hdr(6'h01, 16'd0, 1'b1);
        check("fe_pulse", {31'd0, frame_end}, 32'd1);
        check("fe_frame_count", {16'd0, frame_count}, 32'd1);
        check("fe_in_frame", {31'd0, in_frame}, 32'd0);

        // Pixel line WC=10: be F, F, 3
        send_hdr(6'h00, 16'd0, 1'b1);
        send_hdr(6'h2A, 16'd10, 1'b1);
        check("px_rec_hdr", {31'd0, rec_data}, 32'd1);
        expect_pix(32'h1111_0001, 4'hF, 1'b1);
        send_word(32'h1111_0001);
        check("px_rec_w1", {31'd0, rec_data}, 32'd1);
        expect_pix(32'h2222_0002, 4'hF, 1'b0);
        send_word(32'h2222_0002);
        check("px_rec_w2", {31'd0, rec_data}, 32'd1);
        expect_pix(32'h3333_0003, 4'h3, 1'b0);
        send_word(32'h3333_0003);
        check("px_rec_w3", {31'd0, rec_data}, 32'd0);
        check("px_line_count", {20'd0, line_count}, 32'd1);

        // Non-pixel long packet DT 0x12 WC=8
        send_hdr(6'h12, 16'd8, 1'b1);
        send_word(32'hAAAA_0001);
        send_word(32'hAAAA_0002);
        check("np_rec_w2", {31'd0, rec_data}, 32'd1);
        send_word(32'hAAAA_0003);
        check("np_rec_w3", {31'd0, rec_data}, 32'd0);
        check("np_line_count", {20'd0, line_count}, 32'd1);

        // WC=0 pixel packet: one word ends it, no pixel output
        send_hdr(6'h2A, 16'd0, 1'b1);
        send_word(32'hBBBB_0001);
        check("wc0_rec", {31'd0, rec_data}, 32'd0);

        // Pixel packet outside a frame is consumed silently
        send_hdr(6'h01, 16'd0, 1'b1);
        check("fe2_frame_count", {16'd0, frame_count}, 32'd2);
        send_hdr(6'h2A, 16'd4, 1'b1);
        send_word(32'hCCCC_0001);
        check("oof_rec_w1", {31'd0, rec_data}, 32'd1);
        send_word(32'hCCCC_0002);
        check("oof_rec_w2", {31'd0, rec_data}, 32'd0);

        // ECC error, clear, and error-beats-clear
        send_hdr(6'h00, 16'd0, 1'b0);
        check("ecc_set", {31'd0, err_ecc}, 32'd1);
        check("ecc_no_fs", {31'd0, frame_start}, 32'd0);
        check("ecc_rec", {31'd0, rec_data}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ecc_clr", {31'd0, err_ecc}, 32'd0);
        err_clr = 1'b1;
        send_hdr(6'h2A, 16'd8, 1'b0);
        err_clr = 1'b0;
        check("ecc_wins_clr", {31'd0, err_ecc}, 32'd1);
        check("ecc_stay_idle", {31'd0, rec_data}, 32'd0);

        // Timeout after two words of a WC=100 line
        send_hdr(6'h00, 16'd0, 1'b1);
        send_hdr(6'h2A, 16'd100, 1'b1);
        expect_pix(32'hD000_0001, 4'hF, 1'b1);
        send_word(32'hD000_0001);
        expect_pix(32'hD000_0002, 4'hF, 1'b0);
        send_word(32'hD000_0002);
        n = 0;
        while (err_timeout !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 32'd256);
        check("timeout_rec", {31'd0, rec_data}, 32'd0);
        check("timeout_line_count", {20'd0, line_count}, 32'd0);
        send_hdr(6'h00, 16'd0, 1'b1);
        check("timeout_fs_ok", {31'd0, frame_start}, 32'd1);

        // Truncation: hs_active drops after word 5 with a dropped word
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_all", {29'd0, err_ecc, err_timeout, err_trunc}, 32'd0);
        send_hdr(6'h2A, 16'd100, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            expect_pix(32'hE000_0000 + i, 4'hF, (i == 1));
            send_word(32'hE000_0000 + i);
        end
        hs_active  = 1'b0;
        word_valid = 1'b1;
        word       = 32'hE000_00FF;
        tick();
        hs_active  = 1'b1;
        word_valid = 1'b0;
        check("trunc_set", {31'd0, err_trunc}, 32'd1);
        check("trunc_rec", {31'd0, rec_data}, 32'd0);
        check("trunc_drop", {31'd0, pix_valid}, 32'd0);

        // Asynchronous reset mid-PAYLOAD
        send_hdr(6'h2A, 16'd100, 1'b1);
        send_word(32'hF000_0001);
        check("pre_rst_pix", {31'd0, pix_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_rec", {31'd0, rec_data}, 32'd0);
        check("arst_pix", {30'd0, pix_valid, line_start}, 32'd0);
        check("arst_in_frame", {31'd0, in_frame}, 32'd0);
        check("arst_errs", {29'd0, err_ecc, err_timeout, err_trunc}, 32'd0);
        check("arst_frame_count", {16'd0, frame_count}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csi_packet_sequencer.md
Name: csi_packet_sequencer

Overview:
- Packet-level controller for the 2-lane CSI-2 receive path. Sits after the header/ECC stage and the 32-bit word assembler, on the quarter-rate byte clock domain.
- Takes validated packet headers and payload words; tracks frame and line state; gates pixel words out with byte enables; skips unwanted long packets and CRC.
- Drives rec_data to the SoT FSM so HS reception is held for exactly one packet. Flags ECC, timeout and truncation errors.

Parameters:
- DT_PIXEL, 6'h2A, long-packet data type forwarded as pixels (RAW8)
- TIMEOUT_CYC, 256, max idle cycles between payload words before abort
- LINE_W, 12, width of line_count
- FRAME_W, 16, width of frame_count

Ports:
- sys_clk  in  1  byte-word clock
- reset  in  1  asynchronous reset, active high
- hs_active  in  1  high while the SoT FSM has HS receive enabled
- hdr_valid  in  1  one-cycle strobe: hdr carries a packet header
- hdr  in  32  {ECC[31:24], WC[23:8], VC[7:6], DT[5:0]}
- ecc_ok  in  1  qualifies hdr_valid; header ECC matched
- word_valid  in  1  one-cycle strobe: word carries 4 payload bytes, byte 0 in [7:0]
- word  in  32  payload word
- err_clr  in  1  clears sticky error flags
- rec_data  out  1  packet in progress; holds SoT FSM in HEADER
- pix_valid  out  1  pixel word strobe
- pix_data  out  32  pixel word
- pix_be  out  4  byte enables for pix_data
- frame_start  out  1  one-cycle pulse on FS
- frame_end  out  1  one-cycle pulse on FE
- line_start  out  1  one-cycle pulse at the first pixel word of each line
- in_frame  out  1  between FS and FE
- line_count  out  LINE_W  pixel lines received in the current frame
- frame_count  out  FRAME_W  completed frames
- err_ecc  out  1  sticky; header rejected
- err_timeout  out  1  sticky; payload stalled
- err_trunc  out  1  sticky; hs_active dropped mid-packet

Behaviour:
- Reset, asynchronous: every output 0; state IDLE.
- All outputs are registered. Each output appears 1 cycle after the input that causes it.
- State IDLE:
  - hdr_valid & !ecc_ok: set err_ecc; stay in IDLE.
  - hdr_valid & ecc_ok & DT<6'h10 (short packet):
    - DT 0x00 (FS): pulse frame_start; in_frame<=1; line_count<=0.
    - DT 0x01 (FE): pulse frame_end; in_frame<=0; frame_count+1, wraps.
    - DT 0x02/0x03 (LS/LE): ignored.
    - Any other short DT: ignored.
    - Stay in IDLE.
  - hdr_valid & ecc_ok & DT>=6'h10 (long packet): load remaining<=WC+2 (17 bits, covers the CRC bytes); set fwd<=(DT==DT_PIXEL & in_frame), wc_left<=WC; go to PAYLOAD; rec_data<=1.
  - word_valid in IDLE is ignored.
- State PAYLOAD:
  - On each word_valid: remaining -= 4, saturating at 0.
  - If fwd and wc_left>0: pix_valid<=1; pix_data<=word; pix_be = bytes still inside WC (wc_left>=4 -> 4'hF; 3 -> 4'h7; 2 -> 4'h3; 1 -> 4'h1); wc_left -= min(4, wc_left).
  - Words carrying only CRC bytes never raise pix_valid.
  - line_start pulses with the first pix_valid of the packet. line_count+1 at packet end if fwd, wraps.
  - When remaining<=4 on a word_valid: go to IDLE; rec_data<=0.
  - hdr_valid in PAYLOAD is ignored.
- Timeout: idle counter resets on word_valid. If it reaches TIMEOUT_CYC: set err_timeout, go to IDLE, rec_data<=0. line_count is not incremented.
- Truncation: hs_active low in PAYLOAD sets err_trunc and goes to IDLE the next cycle. Takes priority over a simultaneous word_valid, which is dropped.
- Non-pixel long packets (DT!=DT_PIXEL) and pixel packets arriving outside a frame are consumed silently with rec_data high.
- err_clr clears all three error flags. A simultaneous error event wins: that flag stays set.
- WC=0 long packet: remaining=2; one word ends the packet; no pix_valid, no line_start.

Decomposition:
- Package csi_pkg holds:
  - DT constants: DT_FS=0, DT_FE=1, DT_LS=2, DT_LE=3, DT_LONG_MIN=6'h10.
  - Header field slice positions.
  - State encoding: IDLE, PAYLOAD.
- One natural sub-module: csi_byte_counter. It holds remaining/wc_left, the pix_be generation and the last-word detect.

Test Plan:
- FS header (hdr=32'h..000000, ecc_ok=1) -> frame_start pulse, in_frame=1, line_count=0. Then FE -> frame_end pulse, frame_count 0->1.
- FS, then DT 0x2A WC=10 and 3 words -> pix_be F, F, 3; line_start on word 1; rec_data high for 3 words then low; line_count=1.
- Long DT 0x12 WC=8, 3 words -> no pix_valid; rec_data drops after word 3; line_count unchanged.
- hdr_valid with ecc_ok=0 -> err_ecc=1, state stays IDLE. err_clr -> err_ecc=0.
- WC=100, 2 words, then silence for TIMEOUT_CYC -> err_timeout=1, rec_data=0. A new FS is then accepted.
- WC=100, hs_active drops after word 5 -> err_trunc=1 next cycle, rec_data=0. Assert reset mid-PAYLOAD -> all outputs 0 immediately.
